// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes/functs
// and the datapath select encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_RWB, S_IEXEC, S_IWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_JR, S_JAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;

  localparam logic [1:0] PC_ALU  = 2'd0;
  localparam logic [1:0] PC_OUT  = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;
  localparam logic [1:0] PC_RS   = 2'd3;

  localparam logic [1:0] SB_RT   = 2'd0;
  localparam logic [1:0] SB_FOUR = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_IMM4 = 2'd3;

  localparam logic [1:0] RD_RT   = 2'd0;
  localparam logic [1:0] RD_RD   = 2'd1;
  localparam logic [1:0] RD_RA   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MDR  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;

endpackage

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: ALU operation plus a valid flag for illegal-funct detection.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_SLL:  alu_op = ALU_SLL;
      FN_SRL:  alu_op = ALU_SRL;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM. Outputs decode the registered state.
// Define MC_CTRL_JAL_EN to add jal (opcode 0x03); otherwise it decodes as illegal.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       CEN,
  output logic       WEN,
  output logic       OEN,
  output logic       retire,
  output logic       illegal
);

  state_t     state, d_next;
  logic       d_legal;
  logic       sel_bne, sel_sw;
  logic [2:0] fn_op;
  logic       fn_ok;

  mips_alu_dec u_alu_dec (.funct(funct), .alu_op(fn_op), .valid(fn_ok));

  always_comb begin
    d_next  = S_FETCH;
    d_legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) d_next = S_JR;
        else if (fn_ok)     d_next = S_EXEC;
        else                d_legal = 1'b0;
      end
      OP_LW, OP_SW:   d_next = S_MEMADR;
      OP_ADDI:        d_next = S_IEXEC;
      OP_BEQ, OP_BNE: d_next = S_BRANCH;
      OP_J:           d_next = S_JUMP;
`ifdef MC_CTRL_JAL_EN
      OP_JAL:         d_next = S_JAL;
`endif
      default:        d_legal = 1'b0;
    endcase
  end

  // Opcode is only valid in DECODE, so the beq/bne and lw/sw choice is latched there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      sel_bne <= 1'b0;
      sel_sw  <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          state   <= d_next;
          sel_bne <= (opcode == OP_BNE);
          sel_sw  <= (opcode == OP_SW);
        end
        S_EXEC:   state <= S_RWB;
        S_IEXEC:  state <= S_IWB;
        S_MEMADR: state <= sel_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state <= S_MEMWB;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Gating with rst_n drops any strobe or write the instant reset asserts.
  always_comb begin
    pc_we = 1'b0; pc_src = PC_ALU; ir_we = 1'b0; reg_we = 1'b0;
    reg_dst = RD_RT; mem_to_reg = WB_ALU; alu_src_a = 1'b0; alu_src_b = SB_RT;
    alu_op = ALU_ADD; CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
    retire = 1'b0; illegal = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH:  begin ir_we = 1'b1; pc_we = 1'b1; alu_src_b = SB_FOUR; end
        S_DECODE: begin
          alu_src_b = SB_IMM4;
          illegal   = ~d_legal;
          retire    = ~d_legal;
        end
        S_EXEC:   begin alu_src_a = 1'b1; alu_op = fn_op; end
        S_RWB:    begin reg_we = 1'b1; reg_dst = RD_RD; retire = 1'b1; end
        S_IEXEC, S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = SB_IMM; end
        S_IWB:    begin reg_we = 1'b1; retire = 1'b1; end
        S_MEMRD:  begin CEN = 1'b0; OEN = 1'b0; end
        S_MEMWB:  begin OEN = 1'b0; reg_we = 1'b1; mem_to_reg = WB_MDR; retire = 1'b1; end
        S_MEMWR:  begin CEN = 1'b0; WEN = 1'b0; retire = 1'b1; end
        S_BRANCH: begin
          alu_src_a = 1'b1; alu_op = ALU_SUB; pc_src = PC_OUT; retire = 1'b1;
          pc_we     = sel_bne ? ~zero : zero;
        end
        S_JUMP:   begin pc_src = PC_JMP; pc_we = 1'b1; retire = 1'b1; end
        S_JR:     begin pc_src = PC_RS;  pc_we = 1'b1; retire = 1'b1; end
        S_JAL:    begin
          pc_src = PC_JMP; pc_we = 1'b1; reg_we = 1'b1;
          reg_dst = RD_RA; mem_to_reg = WB_PC; retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed, table-driven bench for mips_mc_ctrl: one table row per clock cycle,
// plus hand sequences for asynchronous reset in MEMWR and RWB.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h3F;
  logic [5:0] funct = 6'h3F;
  logic       zero = 1'b0;
  logic       pc_we, ir_we, reg_we, alu_src_a, CEN, WEN, OEN, retire, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op;

  int total = 0;
  int bad = 0;

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .CEN(CEN), .WEN(WEN), .OEN(OEN),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [19:0] exp;
    string       name;
  } vec_t;

  vec_t tv[$];

  // Expected-vector layout: {pc_we, pc_src, ir_we, reg_we, reg_dst, mem_to_reg,
  // alu_src_a, alu_src_b, alu_op, CEN, WEN, OEN, retire, illegal}
  function automatic logic [19:0] mk(input logic pw, input logic [1:0] ps, input logic ir,
                                     input logic rw, input logic [1:0] rd, input logic [1:0] wb,
                                     input logic sa, input logic [1:0] sb, input logic [2:0] ao,
                                     input logic ce, input logic we, input logic oe,
                                     input logic rt, input logic il);
    return {pw, ps, ir, rw, rd, wb, sa, sb, ao, ce, we, oe, rt, il};
  endfunction

  function automatic logic [19:0] got();
    return {pc_we, pc_src, ir_we, reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
            alu_op, CEN, WEN, OEN, retire, illegal};
  endfunction

  logic [19:0] E_F, E_D, E_DI, E_RWB, E_IEX, E_IWB, E_MRD, E_MWB, E_MWR;
  logic [19:0] E_JMP, E_JR, E_JAL, E_DEF;

  task automatic check(input string name, input logic [19:0] exp);
    total++;
    if (got() !== exp) begin
      bad++;
      $display("FAIL %s: got %05h expected %05h", name, got(), exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [19:0] exp, input string name);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.exp = exp; v.name = name;
    tv.push_back(v);
  endtask

  // Drive inputs just after a falling edge, compare, then advance one cycle.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                      input logic [19:0] exp, input string name);
    opcode = op; funct = fn; zero = z;
    #1;
    check(name, exp);
    @(negedge clk);
  endtask

  initial begin
    E_F   = mk(1,0,1,0,0,0,0,1,0,1,1,1,0,0);
    E_D   = mk(0,0,0,0,0,0,0,3,0,1,1,1,0,0);
    E_DI  = mk(0,0,0,0,0,0,0,3,0,1,1,1,1,1);
    E_RWB = mk(0,0,0,1,1,0,0,0,0,1,1,1,1,0);
    E_IEX = mk(0,0,0,0,0,0,1,2,0,1,1,1,0,0);
    E_IWB = mk(0,0,0,1,0,0,0,0,0,1,1,1,1,0);
    E_MRD = mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0);
    E_MWB = mk(0,0,0,1,0,1,0,0,0,1,1,0,1,0);
    E_MWR = mk(0,0,0,0,0,0,0,0,0,0,0,1,1,0);
    E_JMP = mk(1,2,0,0,0,0,0,0,0,1,1,1,1,0);
    E_JR  = mk(1,3,0,0,0,0,0,0,0,1,1,1,1,0);
    E_JAL = mk(1,2,0,1,2,2,0,0,0,1,1,1,1,0);
    E_DEF = mk(0,0,0,0,0,0,0,0,0,1,1,1,0,0);

    // lw: 5 cycles, read strobe in cycle 4 only
    add(6'h3F, 6'h3F, 0, E_F,   "lw_c1");
    add(6'h23, 6'h00, 0, E_D,   "lw_c2");
    add(6'h3F, 6'h3F, 0, E_IEX, "lw_c3_memadr");
    add(6'h3F, 6'h3F, 0, E_MRD, "lw_c4_memrd");
    add(6'h3F, 6'h3F, 0, E_MWB, "lw_c5_memwb");
    // sw: 4 cycles
    add(6'h00, 6'h00, 0, E_F,   "sw_c1");
    add(6'h2B, 6'h00, 0, E_D,   "sw_c2");
    add(6'h23, 6'h3F, 0, E_IEX, "sw_c3_memadr");
    add(6'h23, 6'h3F, 0, E_MWR, "sw_c4_memwr");
    // beq taken / not taken, bne taken / not taken
    add(6'h3F, 6'h3F, 0, E_F,   "beq1_c1");
    add(6'h04, 6'h00, 0, E_D,   "beq1_c2");
    add(6'h05, 6'h00, 1, mk(1,1,0,0,0,0,1,0,1,1,1,1,1,0), "beq_z1_c3");
    add(6'h3F, 6'h3F, 1, E_F,   "beq0_c1");
    add(6'h04, 6'h00, 1, E_D,   "beq0_c2");
    add(6'h05, 6'h00, 0, mk(0,1,0,0,0,0,1,0,1,1,1,1,1,0), "beq_z0_c3");
    add(6'h3F, 6'h3F, 0, E_F,   "bne0_c1");
    add(6'h05, 6'h00, 0, E_D,   "bne0_c2");
    add(6'h04, 6'h00, 0, mk(1,1,0,0,0,0,1,0,1,1,1,1,1,0), "bne_z0_c3");
    add(6'h3F, 6'h3F, 0, E_F,   "bne1_c1");
    add(6'h05, 6'h00, 0, E_D,   "bne1_c2");
    add(6'h04, 6'h00, 1, mk(0,1,0,0,0,0,1,0,1,1,1,1,1,0), "bne_z1_c3");
    // R-type sub and slt, alu_op follows funct in EXEC
    add(6'h3F, 6'h3F, 0, E_F,   "sub_c1");
    add(6'h00, 6'h22, 0, E_D,   "sub_c2");
    add(6'h3F, 6'h22, 0, mk(0,0,0,0,0,0,1,0,1,1,1,1,0,0), "sub_c3_exec");
    add(6'h3F, 6'h3F, 0, E_RWB, "sub_c4_rwb");
    add(6'h3F, 6'h3F, 0, E_F,   "slt_c1");
    add(6'h00, 6'h2A, 0, E_D,   "slt_c2");
    add(6'h3F, 6'h2A, 0, mk(0,0,0,0,0,0,1,0,4,1,1,1,0,0), "slt_c3_exec");
    add(6'h3F, 6'h3F, 0, E_RWB, "slt_c4_rwb");
    add(6'h3F, 6'h3F, 0, E_F,   "srl_c1");
    add(6'h00, 6'h02, 0, E_D,   "srl_c2");
    add(6'h3F, 6'h02, 0, mk(0,0,0,0,0,0,1,0,6,1,1,1,0,0), "srl_c3_exec");
    add(6'h3F, 6'h3F, 0, E_RWB, "srl_c4_rwb");
    // addi
    add(6'h3F, 6'h3F, 0, E_F,   "addi_c1");
    add(6'h08, 6'h3F, 0, E_D,   "addi_c2");
    add(6'h3F, 6'h3F, 0, E_IEX, "addi_c3");
    add(6'h3F, 6'h3F, 0, E_IWB, "addi_c4");
    // j and jr
    add(6'h3F, 6'h3F, 0, E_F,   "j_c1");
    add(6'h02, 6'h00, 0, E_D,   "j_c2");
    add(6'h3F, 6'h3F, 0, E_JMP, "j_c3");
    add(6'h3F, 6'h3F, 0, E_F,   "jr_c1");
    add(6'h00, 6'h08, 0, E_D,   "jr_c2");
    add(6'h3F, 6'h3F, 0, E_JR,  "jr_c3");
    // illegal opcode and illegal R-type funct: pulse in cycle 2, then FETCH
    add(6'h3F, 6'h3F, 0, E_F,   "ilop_c1");
    add(6'h3F, 6'h00, 0, E_DI,  "ilop_c2");
    add(6'h3F, 6'h3F, 0, E_F,   "ilfn_c1");
    add(6'h00, 6'h3F, 0, E_DI,  "ilfn_c2");
    // opcode 0x03
    add(6'h3F, 6'h3F, 0, E_F,   "jal_c1");
`ifdef MC_CTRL_JAL_EN
    add(6'h03, 6'h00, 0, E_D,   "jal_c2");
    add(6'h3F, 6'h3F, 0, E_JAL, "jal_c3");
`else
    add(6'h03, 6'h00, 0, E_DI,  "jal_c2_illegal");
`endif
    add(6'h3F, 6'h3F, 0, E_F,   "after_c1");

    // Reset held for 3 cycles, outputs at defaults throughout
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("reset_%0d", i), E_DEF);
    end
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      step(tv[i].op, tv[i].fn, tv[i].z, tv[i].exp, tv[i].name);

    // after_c1 left the FSM in DECODE: run a sw up to MEMWR, then reset mid-cycle
    step(6'h2B, 6'h00, 0, E_D,   "rsw_c2");
    step(6'h3F, 6'h3F, 0, E_IEX, "rsw_c3");
    opcode = 6'h3F; funct = 6'h3F;
    #1 check("rsw_c4_memwr", E_MWR);
    #2 rst_n = 1'b0;
    #1 check("rsw_reset_now", E_DEF);
    @(negedge clk);
    #1 check("rsw_reset_hold", E_DEF);
    rst_n = 1'b1;
    step(6'h3F, 6'h3F, 0, E_F, "rsw_refetch");

    // R-type add up to RWB, then reset mid-cycle
    step(6'h00, 6'h20, 0, E_D, "rrwb_c2");
    step(6'h3F, 6'h20, 0, mk(0,0,0,0,0,0,1,0,0,1,1,1,0,0), "rrwb_c3_exec");
    #1 check("rrwb_c4_rwb", E_RWB);
    #2 rst_n = 1'b0;
    #1 check("rrwb_reset_now", E_DEF);
    @(negedge clk);
    rst_n = 1'b1;
    step(6'h3F, 6'h3F, 0, E_F, "rrwb_refetch");
    step(6'h08, 6'h00, 0, E_D, "rrwb_decode");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
